serial_datapath: RTL and testbench

SERIAL_DATAPATH -- requirements
Module: serial_datapath

---
 rtl/serial_datapath_if.sv | 26 ++
 rtl/serial_datapath.sv | 82 ++++++++
 tb/tb_serial_datapath.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/serial_datapath_if.sv
// Control/operand bundle and register-file outputs of the bit-serial datapath.
interface serial_datapath_if;
    logic [7:0] i_sw;
    logic [2:0] i_con_mux8;
    logic       i_con_mux;
    logic       i_con_muxalu;
    logic       i_con_gpr_region;
    logic       i_con_gpr_write;
    logic       i_con_gpr_shift;
    logic [7:0] o_r0;
    logic [7:0] o_r1;
    logic       o_cout;
    logic       o_done;

    modport master (
        output i_sw, i_con_mux8, i_con_mux, i_con_muxalu,
               i_con_gpr_region, i_con_gpr_write, i_con_gpr_shift,
        input  o_r0, o_r1, o_cout, o_done
    );

    modport slave (
        input  i_sw, i_con_mux8, i_con_mux, i_con_muxalu,
               i_con_gpr_region, i_con_gpr_write, i_con_gpr_shift,
        output o_r0, o_r1, o_cout, o_done
    );
endinterface

// File: rtl/serial_datapath.sv
// Bit-serial two-register datapath: one-bit ALU, LSB-first; load, copy and add
// each take eight shift steps driven by an external sequencer.
module serial_datapath (
    input  logic               i_clk,
    input  logic               i_rst_n,
    serial_datapath_if.slave   dp
);

    logic [7:0] r0_q, r0_d;
    logic [7:0] r1_q, r1_d;
    logic       c_q, c_d;
    logic       cout_q, cout_d;
    logic       done_q, done_d;

    logic cin;
    logic sum_bit;
    logic alu_bit;
    logic alu_carry;
    logic sin_bit;
    logic tgt_msb;

    // Carry-in is forced low on step 0 so a stale carry never leaks into a new add.
    always_comb begin
        cin       = (dp.i_con_mux8 == 3'd0) ? 1'b0 : c_q;
        sum_bit   = r0_q[0] ^ r1_q[0] ^ cin;
        alu_carry = (r0_q[0] & r1_q[0]) | (r0_q[0] & cin) | (r1_q[0] & cin);
        alu_bit   = dp.i_con_muxalu ? r0_q[0] : sum_bit;
        sin_bit   = dp.i_con_mux ? dp.i_sw[dp.i_con_mux8] : alu_bit;
    end

    always_comb begin
        r0_d    = r0_q;
        r1_d    = r1_q;
        c_d     = c_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        tgt_msb = 1'b0;
        if (dp.i_con_gpr_shift) begin
            if (dp.i_con_gpr_region == 1'b0) begin
                tgt_msb = (dp.i_con_gpr_write | dp.i_con_muxalu) ? sin_bit : r0_q[0];
                r0_d    = {tgt_msb, r0_q[7:1]};
                r1_d    = {r1_q[0], r1_q[7:1]};
            end else begin
                tgt_msb = (dp.i_con_gpr_write | dp.i_con_muxalu) ? sin_bit : r1_q[0];
                r1_d    = {tgt_msb, r1_q[7:1]};
                r0_d    = {r0_q[0], r0_q[7:1]};
            end
            if (!dp.i_con_muxalu) begin
                c_d = alu_carry;
            end
            // Carry-out is published only when the final step of an add writes back.
            if ((dp.i_con_mux8 == 3'd7) && !dp.i_con_muxalu && !dp.i_con_mux &&
                dp.i_con_gpr_write) begin
                cout_d = alu_carry;
            end
            done_d = (dp.i_con_mux8 == 3'd7) && dp.i_con_gpr_write &&
                     (dp.i_con_gpr_region == 1'b0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r0_q   <= 8'h00;
            r1_q   <= 8'h00;
            c_q    <= 1'b0;
            cout_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            r0_q   <= r0_d;
            r1_q   <= r1_d;
            c_q    <= c_d;
            cout_q <= cout_d;
            done_q <= done_d;
        end
    end

    assign dp.o_r0   = r0_q;
    assign dp.o_r1   = r1_q;
    assign dp.o_cout = cout_q;
    assign dp.o_done = done_q;

endmodule

// File: tb/tb_serial_datapath.sv
// Randomised whole-operation bench for serial_datapath against a byte-level model.
module tb_serial_datapath;

    localparam int OP_LOAD = 0;
    localparam int OP_COPY = 1;
    localparam int OP_ADD  = 2;

    logic clk;
    logic rst_n;
    serial_datapath_if dp_if ();

    serial_datapath dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .dp      (dp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [7:0] m_r0;
    logic [7:0] m_r1;
    logic       m_cout;

    always @(negedge clk) begin
        if (dp_if.o_done === 1'b1) done_cnt++;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        dp_if.i_con_gpr_shift  = 1'b0;
        dp_if.i_con_mux8       = 3'($urandom_range(0, 7));
        dp_if.i_con_mux        = 1'($urandom);
        dp_if.i_con_muxalu     = 1'($urandom);
        dp_if.i_con_gpr_region = 1'($urandom);
        dp_if.i_con_gpr_write  = 1'($urandom);
        dp_if.i_sw             = 8'($urandom);
    endtask

    task automatic drive_bit(input int op, input int b, input logic [7:0] sw);
        dp_if.i_con_gpr_shift = 1'b1;
        dp_if.i_con_mux8      = 3'(b);
        case (op)
            OP_LOAD: begin
                dp_if.i_con_mux = 1'b1; dp_if.i_con_muxalu = 1'b0;
                dp_if.i_con_gpr_region = 1'b0; dp_if.i_con_gpr_write = 1'b1;
                dp_if.i_sw = sw;
            end
            OP_COPY: begin
                dp_if.i_con_mux = 1'b0; dp_if.i_con_muxalu = 1'b1;
                dp_if.i_con_gpr_region = 1'b1; dp_if.i_con_gpr_write = 1'($urandom);
                dp_if.i_sw = 8'($urandom);
            end
            default: begin
                dp_if.i_con_mux = 1'b0; dp_if.i_con_muxalu = 1'b0;
                dp_if.i_con_gpr_region = 1'b0; dp_if.i_con_gpr_write = 1'b1;
                dp_if.i_sw = 8'($urandom);
            end
        endcase
    endtask

    // One full operation with an optional stall of gap_len idle cycles before bit gap_at.
    task automatic run_op(input int op, input logic [7:0] sw, input int gap_at, input int gap_len,
                          input string tag);
        int done_before;
        logic [8:0] wide;
        int exp_done;
        done_before = done_cnt;
        for (int b = 0; b < 8; b++) begin
            if (b == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    drive_idle();
                    @(posedge clk);
                end
            end
            @(negedge clk);
            drive_bit(op, b, sw);
            @(posedge clk);
        end
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        case (op)
            OP_LOAD: begin m_r0 = sw; exp_done = 1; end
            OP_COPY: begin m_r1 = m_r0; exp_done = 0; end
            default: begin
                wide   = {1'b0, m_r0} + {1'b0, m_r1};
                m_r0   = wide[7:0];
                m_cout = wide[8];
                exp_done = 1;
            end
        endcase
        $display("op=%0d sw=%02h gap_at=%0d gap_len=%0d -> r0=%02h r1=%02h cout=%0b",
                 op, sw, gap_at, gap_len, dp_if.o_r0, dp_if.o_r1, dp_if.o_cout);
        check_value({tag, "_r0"},   32'(dp_if.o_r0),   32'(m_r0));
        check_value({tag, "_r1"},   32'(dp_if.o_r1),   32'(m_r1));
        check_value({tag, "_cout"}, 32'(dp_if.o_cout), 32'(m_cout));
        check_value({tag, "_done"}, 32'(done_cnt - done_before), 32'(exp_done));
    endtask

    initial begin
        int op;
        rst_n = 1'b0;
        drive_idle();
        m_r0 = 8'h00; m_r1 = 8'h00; m_cout = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("reset_r0",   32'(dp_if.o_r0),   32'h0);
        check_value("reset_r1",   32'(dp_if.o_r1),   32'h0);
        check_value("reset_cout", 32'(dp_if.o_cout), 32'h0);
        check_value("reset_done", 32'(dp_if.o_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);

        run_op(OP_LOAD, 8'hA5, 8, 0, "load_a5");

        run_op(OP_LOAD, 8'h3C, 8, 0, "seq_load3c");
        run_op(OP_COPY, 8'h00, 8, 0, "seq_copy");
        run_op(OP_LOAD, 8'h0F, 8, 0, "seq_load0f");
        run_op(OP_ADD,  8'h00, 8, 0, "seq_add4b");
        check_value("add_4b_value", 32'(dp_if.o_r0), 32'h4B);

        run_op(OP_LOAD, 8'h01, 8, 0, "ovf_load01");
        run_op(OP_COPY, 8'h00, 8, 0, "ovf_copy");
        run_op(OP_LOAD, 8'hFF, 8, 0, "ovf_loadff");
        run_op(OP_ADD,  8'h00, 8, 0, "ovf_add");
        check_value("ovf_cout_set", 32'(dp_if.o_cout), 32'h1);
        run_op(OP_LOAD, 8'h7F, 8, 0, "cin_load7f");
        run_op(OP_COPY, 8'h00, 8, 0, "cin_copy");
        run_op(OP_LOAD, 8'h80, 8, 0, "cin_load80");
        run_op(OP_ADD,  8'h00, 8, 0, "cin_add");
        check_value("cin_cleared_r0", 32'(dp_if.o_r0), 32'hFF);

        run_op(OP_LOAD, 8'h5A, 8, 0, "gap_load");
        run_op(OP_COPY, 8'h00, 8, 0, "gap_copy");
        run_op(OP_LOAD, 8'hC7, 8, 0, "gap_load2");
        run_op(OP_ADD,  8'h00, 4, 3, "gap_add");

        // Asynchronous reset in the middle of an add, clearing before any clock edge.
        for (int b = 0; b <= 4; b++) begin
            @(negedge clk);
            drive_bit(OP_ADD, b, 8'h00);
            if (b < 4) @(posedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_value("async_rst_r0",   32'(dp_if.o_r0),   32'h0);
        check_value("async_rst_r1",   32'(dp_if.o_r1),   32'h0);
        check_value("async_rst_cout", 32'(dp_if.o_cout), 32'h0);
        check_value("async_rst_done", 32'(dp_if.o_done), 32'h0);
        drive_idle();
        m_r0 = 8'h00; m_r1 = 8'h00; m_cout = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        run_op(OP_LOAD, 8'h12, 8, 0, "post_rst_load");

        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 2));
            run_op(op, 8'($urandom), int'($urandom_range(0, 8)), int'($urandom_range(0, 3)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
